// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM/status codes,
// data-width limits and the Hamming codeword layout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int MIN_DATA_BITS = 4;
    localparam int MAX_DATA_BITS = 8;
    localparam int NUM_PARITY    = 4;
    localparam int CW_W          = 14;

    localparam int P0_IDX = 13;
    localparam int P1_IDX = 12;
    localparam int P2_IDX = 10;
    localparam int P3_IDX = 6;

    // Codeword positions covered by each parity bit.
    localparam logic [CW_W-1:0] P0_COVER = 14'b00_1010_1010_1010;  // 11,9,7,5,3,1
    localparam logic [CW_W-1:0] P1_COVER = 14'b00_1001_1001_1001;  // 11,8,7,4,3,0
    localparam logic [CW_W-1:0] P2_COVER = 14'b00_0011_1000_0111;  // 9,8,7,2,1,0
    localparam logic [CW_W-1:0] P3_COVER = 14'b00_0000_0011_1111;  // 5..0

    // Codeword position of data bit i.
    function automatic int data_pos(input int i);
        case (i)
            0:       return 11;
            1:       return 9;
            2:       return 8;
            3:       return 7;
            4:       return 5;
            5:       return 4;
            6:       return 3;
            7:       return 2;
            8:       return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_encoder.sv
// Combinational Hamming encoder: scatters data bits into the 14-bit codeword
// and fills the four parity positions.
module uart_tx_encoder
    import uart_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   cw
);

    logic [CW_W-1:0] body;

    always_comb begin
        body = '0;
        for (int i = 0; i < DATA_W; i++) begin
            body[data_pos(i)] = data[i];
        end
        cw         = body;
        cw[P0_IDX] = ^(body & P0_COVER);
        cw[P1_IDX] = ^(body & P1_COVER);
        cw[P2_IDX] = ^(body & P2_COVER);
        cw[P3_IDX] = ^(body & P3_COVER);
    end

endmodule

// File: rtl/uart_tx_wrapper.sv
// UART transmitter: valid/ready handshake, Hamming encode at transfer, then
// start bit, top N codeword bits MSB first, and one or two stop bits.
module uart_tx_wrapper #(
    parameter int DATA_W = 10,
    parameter int CW_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_ena,
    input  logic              tx_cts,
    input  logic [4:0]        tx_config,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic [1:0]        status,
    output logic              tx_done,
    output logic              tx_err
);
    import uart_pkg::*;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [3:0]        nbits_q;
    logic              two_stop_q;
    logic [CW_W-1:0]   cw_q;
    logic [CW_W-1:0]   cw_enc;
    logic [DATA_W-1:0] data_masked;
    logic [3:0]        bit_idx;
    logic              serial_nx, done_nx, err_nx;
    logic              xfer, cfg_ok;

    assign tx_ready = (state == IDLE) && tx_ena && tx_cts;
    assign xfer     = tx_valid && tx_ready;
    assign cfg_ok   = (tx_config[3:0] >= 4'(MIN_DATA_BITS)) &&
                      (tx_config[3:0] <= 4'(MAX_DATA_BITS));
    assign status   = state;

    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            data_masked[i] = tx_data[i] & (4'(i) < tx_config[3:0]);
        end
    end

    uart_tx_encoder #(.DATA_W(DATA_W)) u_encoder (
        .data (data_masked),
        .cw   (cw_enc)
    );

    // Outputs are computed for the state being entered so that serial_out and
    // status change on the same edge.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        serial_nx = 1'b1;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        bit_idx   = 4'(CW_W - 2) - cnt;
        if (!tx_ena) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (cfg_ok) begin
                            state_nx  = START;
                            serial_nx = 1'b0;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                end
                START: begin
                    state_nx  = DATA;
                    cnt_nx    = '0;
                    serial_nx = cw_q[CW_W-1];
                end
                DATA: begin
                    if (cnt == nbits_q + 4'd3) begin
                        state_nx = STOP;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx    = cnt + 4'd1;
                        serial_nx = cw_q[bit_idx];
                    end
                end
                STOP: begin
                    if (two_stop_q && (cnt == 4'd0)) begin
                        cnt_nx = 4'd1;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        done_nx  = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            cw_q       <= '0;
            nbits_q    <= '0;
            two_stop_q <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            serial_out <= serial_nx;
            tx_done    <= done_nx;
            tx_err     <= err_nx;
            if (xfer) begin
                cw_q       <= cw_enc;
                nbits_q    <= tx_config[3:0];
                two_stop_q <= tx_config[4];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// Bench for uart_tx_wrapper: frame-level queue model checked every cycle,
// plus directed frames compared against hand-computed line sequences.
module tb_uart_tx_wrapper;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_ena, tx_cts, tx_valid;
    logic [4:0] tx_config;
    logic [9:0] tx_data;
    logic       tx_ready, serial_out, tx_done, tx_err;
    logic [1:0] status;

    always #5 clk = ~clk;

    uart_tx_wrapper dut (
        .clk        (clk),
        .rst        (rst),
        .tx_ena     (tx_ena),
        .tx_cts     (tx_cts),
        .tx_config  (tx_config),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .status     (status),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: one expected output set per clock cycle.
    typedef struct packed {
        logic       ser;
        logic [1:0] st;
        logic       done;
        logic       err;
    } exp_t;

    localparam exp_t IDLE_E = '{ser: 1'b1, st: 2'd0, done: 1'b0, err: 1'b0};

    exp_t q[$];
    exp_t cur = IDLE_E;

    function automatic logic [13:0] model_cw(input logic [9:0] d, input int nb);
        int dpos [10];
        int grp [4][6];
        int ppos [4];
        logic [13:0] c;
        logic [9:0] m;
        dpos = '{11, 9, 8, 7, 5, 4, 3, 2, 1, 0};
        grp  = '{'{11, 9, 7, 5, 3, 1}, '{11, 8, 7, 4, 3, 0},
                 '{9, 8, 7, 2, 1, 0},  '{5, 4, 3, 2, 1, 0}};
        ppos = '{13, 12, 10, 6};
        m = d & 10'((1 << nb) - 1);
        c = '0;
        for (int i = 0; i < 10; i++) c[dpos[i]] = m[i];
        for (int g = 0; g < 4; g++) begin
            logic p;
            p = 1'b0;
            for (int k = 0; k < 6; k++) p = p ^ c[grp[g][k]];
            c[ppos[g]] = p;
        end
        return c;
    endfunction

    task automatic model_step();
        exp_t nxt;
        int nb;
        logic [13:0] c;
        nxt = IDLE_E;
        if (!tx_ena) begin
            q.delete();
        end else if (cur.st == 2'd0 && tx_cts && tx_valid) begin
            nb = int'(tx_config[3:0]);
            if (nb < 4 || nb > 8) begin
                nxt.err = 1'b1;
            end else begin
                c = model_cw(tx_data, nb);
                q.push_back('{ser: 1'b0, st: 2'd1, done: 1'b0, err: 1'b0});
                for (int k = 0; k < nb + 4; k++)
                    q.push_back('{ser: c[13-k], st: 2'd2, done: 1'b0, err: 1'b0});
                for (int k = 0; k < (tx_config[4] ? 2 : 1); k++)
                    q.push_back('{ser: 1'b1, st: 2'd3, done: 1'b0, err: 1'b0});
                q.push_back('{ser: 1'b1, st: 2'd0, done: 1'b1, err: 1'b0});
                nxt = q.pop_front();
            end
        end else if (q.size() > 0) begin
            nxt = q.pop_front();
        end
        cur = nxt;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                cur = IDLE_E;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_serial", 32'(serial_out), 32'(cur.ser));
            chk("cyc_status", 32'(status), 32'(cur.st));
            chk("cyc_done", 32'(tx_done), 32'(cur.done));
            chk("cyc_err", 32'(tx_err), 32'(cur.err));
            chk("cyc_ready", 32'(tx_ready), 32'((cur.st == 2'd0) && tx_ena && tx_cts));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Directed capture buffers.
    logic       rec_ser  [64];
    logic [1:0] rec_st   [64];
    logic       rec_done [64];

    task automatic record(input int k);
        rec_ser[k]  = serial_out;
        rec_st[k]   = status;
        rec_done[k] = tx_done;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Raise valid for one transfer and record n cycles starting with the start bit.
    // With scramble set, config/data/cts are disturbed once the frame is in flight.
    task automatic send_capture(input logic [4:0] cfg, input logic [9:0] d,
                                input int n, input bit scramble);
        tx_config = cfg;
        tx_data   = d;
        tx_valid  = 1'b1;
        @(negedge clk);
        record(0);
        #1;
        tx_valid = 1'b0;
        if (scramble) begin
            tx_config = 5'b1_0100;
            tx_data   = 10'h3FF;
            tx_cts    = 1'b0;
        end
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            record(k);
        end
        #1;
    endtask

    function automatic logic [31:0] pack_ser(input int first, input int n);
        logic [31:0] v;
        v = '0;
        for (int k = first; k < first + n; k++) v = (v << 1) | 32'(rec_ser[k]);
        return v;
    endfunction

    function automatic logic [31:0] pack_st(input int n);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 2) | 32'(rec_st[k]);
        return v;
    endfunction

    function automatic int count_done(input int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) c += int'(rec_done[k]);
        return c;
    endfunction

    initial begin
        logic [13:0] cw;
        logic [11:0] top12;
        logic [7:0]  top8;
        logic [31:0] st_exp;
        int ones;

        rst       = 1'b1;
        tx_ena    = 1'b1;
        tx_cts    = 1'b1;
        tx_valid  = 1'b0;
        tx_config = 5'b0_1000;
        tx_data   = '0;

        // Model pinning against hand-derived codewords.
        cw    = model_cw(10'h0A5, 8);
        top12 = cw[13:2];
        chk("model_cw_a5", 32'(top12), 32'b1110_0100_0101);
        cw    = model_cw(10'h3FF, 4);
        top8  = cw[13:6];
        chk("model_cw_f", 32'(top8), 32'b1111_1110);

        #3;
        chk("reset_serial", 32'(serial_out), 32'd1);
        chk("reset_status", 32'(status), 32'd0);
        chk("reset_done", 32'(tx_done), 32'd0);
        chk("reset_err", 32'(tx_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 8 data bits, one stop; inputs disturbed mid-frame.
        send_capture(5'b0_1000, 10'h0A5, 15, 1'b1);
        chk("f1_serial", pack_ser(0, 14), 32'b01_1100_1000_1011);
        st_exp = 32'({2'd1, {12{2'd2}}, 2'd3, 2'd0});
        chk("f1_status", pack_st(15), st_exp);
        chk("f1_done_last", 32'(rec_done[14]), 32'd1);
        chk("f1_done_count", 32'(count_done(15)), 32'd1);
        tx_cts = 1'b1;
        tick();

        // 4 data bits (upper payload masked), two stop bits.
        send_capture(5'b1_0100, 10'h3FF, 12, 1'b0);
        chk("f2_serial", pack_ser(0, 11), 32'b011_1111_1011);
        chk("f2_stop2", 32'(rec_st[10]), 32'd3);
        chk("f2_done", 32'(rec_done[11]), 32'd1);
        chk("f2_done_count", 32'(count_done(12)), 32'd1);
        tick();

        // Clear-to-send held low blocks the transfer.
        tx_cts    = 1'b0;
        tx_valid  = 1'b1;
        tx_config = 5'b0_0100;
        tx_data   = 10'h005;
        ones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ones += int'(serial_out);
            chk("cts_ready_low", 32'(tx_ready), 32'd0);
            #1;
        end
        chk("cts_line_idle", 32'(ones), 32'd6);
        tx_cts = 1'b1;
        send_capture(5'b0_0100, 10'h005, 11, 1'b0);
        chk("cts_serial", pack_ser(0, 10), 32'b01_0110_1001);
        chk("cts_done", 32'(rec_done[10]), 32'd1);
        tick();

        // Abort during DATA (cnt=3), then a clean frame.
        send_capture(5'b0_1000, 10'h0A5, 5, 1'b0);
        tx_ena = 1'b0;
        @(negedge clk);
        chk("abort_serial", 32'(serial_out), 32'd1);
        chk("abort_status", 32'(status), 32'd0);
        chk("abort_done", 32'(tx_done), 32'd0);
        chk("abort_ready", 32'(tx_ready), 32'd0);
        #1;
        tx_ena = 1'b1;
        tick();
        send_capture(5'b0_0100, 10'h005, 11, 1'b0);
        chk("reen_serial", pack_ser(0, 10), 32'b01_0110_1001);
        chk("reen_done", 32'(rec_done[10]), 32'd1);
        tick();

        // Invalid data-bit counts 9 and 3.
        for (int t = 0; t < 2; t++) begin
            tx_config = (t == 0) ? 5'b0_1001 : 5'b0_0011;
            tx_valid  = 1'b1;
            @(negedge clk);
            chk("bad_err", 32'(tx_err), 32'd1);
            chk("bad_serial", 32'(serial_out), 32'd1);
            chk("bad_ready", 32'(tx_ready), 32'd1);
            #1;
            tx_valid = 1'b0;
            @(negedge clk);
            chk("bad_err_clear", 32'(tx_err), 32'd0);
            chk("bad_status", 32'(status), 32'd0);
            #1;
        end

        // Asynchronous reset during the first of two stop bits.
        send_capture(5'b1_0100, 10'h3FF, 10, 1'b0);
        chk("pre_rst_status", 32'(rec_st[9]), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_serial", 32'(serial_out), 32'd1);
        chk("arst_status", 32'(status), 32'd0);
        chk("arst_done", 32'(tx_done), 32'd0);
        #10;
        rst = 1'b0;
        tick();

        // Back-to-back: valid held across the done cycle.
        tx_config = 5'b0_0100;
        tx_data   = 10'h005;
        tx_valid  = 1'b1;
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            record(k);
            if (k == 11) begin
                #1;
                tx_valid = 1'b0;
            end
        end
        #1;
        chk("b2b_f1", pack_ser(0, 10), 32'b01_0110_1001);
        chk("b2b_gap_ser", 32'(rec_ser[10]), 32'd1);
        chk("b2b_gap_st", 32'(rec_st[10]), 32'd0);
        chk("b2b_gap_done", 32'(rec_done[10]), 32'd1);
        chk("b2b_f2", pack_ser(11, 10), 32'b01_0110_1001);
        chk("b2b_f2_start_st", 32'(rec_st[11]), 32'd1);
        chk("b2b_f2_done", 32'(rec_done[21]), 32'd1);
        chk("b2b_done_count", 32'(count_done(23)), 32'd2);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
